// File: rtl/lsu_mem_stage.sv
// Load/store stage between execute and writeback.
// Turns a memory op into one valid/ready bus request and returns load data or the ALU result.
module lsu_mem_stage #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  input  logic [2:0]      in_mem_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic            mem_req_wen,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [3:0]      mem_req_wstrb,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam int unsigned TMO_W     = 32;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(RESP_TIMEOUT);
  localparam bit TMO_EN = (RESP_TIMEOUT != 0);

  logic [1:0]      state_q, state_n;
  logic [XLEN-1:0] req_addr_q, req_addr_n;
  logic [XLEN-1:0] req_wdata_q, req_wdata_n;
  logic [3:0]      req_wstrb_q, req_wstrb_n;
  logic            req_wen_q, req_wen_n;
  logic [2:0]      op_q, op_n;
  logic [1:0]      sh_q, sh_n;
  logic [XLEN-1:0] out_data_q, out_data_n;
  logic            err_q, err_n;
  logic [TMO_W-1:0] tmo_q, tmo_n;

  logic [XLEN-1:0] lane_wdata;
  logic [3:0]      lane_wstrb;
  logic            misaligned;
  logic [XLEN-1:0] load_shift;
  logic [XLEN-1:0] load_ext;

  // Store lane replication, byte enables and alignment check from the incoming op
  always_comb begin
    lane_wdata = in_wdata;
    lane_wstrb = 4'b1111;
    misaligned = |in_addr[1:0];
    case (in_mem_op)
      3'b000, 3'b100: begin
        lane_wdata = {4{in_wdata[7:0]}};
        lane_wstrb = 4'b0001 << in_addr[1:0];
        misaligned = 1'b0;
      end
      3'b001, 3'b101: begin
        lane_wdata = {2{in_wdata[15:0]}};
        lane_wstrb = 4'b0011 << in_addr[1:0];
        misaligned = in_addr[0];
      end
      default: ;
    endcase
  end

  // Load extraction from the latched byte offset and op
  always_comb begin
    load_shift = mem_resp_rdata >> {sh_q, 3'b000};
    case (op_q)
      3'b000:  load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
      3'b001:  load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
      3'b100:  load_ext = {24'd0, load_shift[7:0]};
      3'b101:  load_ext = {16'd0, load_shift[15:0]};
      default: load_ext = load_shift;
    endcase
  end

  always_comb begin
    state_n     = state_q;
    req_addr_n  = req_addr_q;
    req_wdata_n = req_wdata_q;
    req_wstrb_n = req_wstrb_q;
    req_wen_n   = req_wen_q;
    op_n        = op_q;
    sh_n        = sh_q;
    out_data_n  = out_data_q;
    err_n       = err_q;
    tmo_n       = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          req_addr_n  = {in_addr[XLEN-1:2], 2'b00};
          req_wen_n   = in_mem_write;
          req_wdata_n = in_mem_write ? lane_wdata : '0;
          req_wstrb_n = in_mem_write ? lane_wstrb : 4'b0000;
          op_n        = in_mem_op;
          sh_n        = in_addr[1:0];
          tmo_n       = '0;
          if (!(in_mem_read || in_mem_write)) begin
            state_n    = S_OUT;
            out_data_n = in_addr;
            err_n      = 1'b0;
          end else if (misaligned) begin
            state_n    = S_OUT;
            out_data_n = '0;
            err_n      = 1'b1;
          end else begin
            state_n = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_n = S_WAIT;
      end
      S_WAIT: begin
        tmo_n = tmo_q + TMO_W'(1);
        // A response in the same cycle as the timeout wins
        if (mem_resp_valid) begin
          state_n    = S_OUT;
          out_data_n = req_wen_q ? '0 : load_ext;
          err_n      = 1'b0;
        end else if (TMO_EN && (tmo_n == TMO_LIMIT)) begin
          state_n    = S_OUT;
          out_data_n = '0;
          err_n      = 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_n = S_IDLE;
          err_n   = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= 4'b0000;
      req_wen_q   <= 1'b0;
      op_q        <= 3'b000;
      sh_q        <= 2'b00;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_n;
      req_addr_q  <= req_addr_n;
      req_wdata_q <= req_wdata_n;
      req_wstrb_q <= req_wstrb_n;
      req_wen_q   <= req_wen_n;
      op_q        <= op_n;
      sh_q        <= sh_n;
      out_data_q  <= out_data_n;
      err_q       <= err_n;
      tmo_q       <= tmo_n;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign out_valid     = (state_q == S_OUT);
  assign mem_req_valid = (state_q == S_REQ);
  assign out_data      = out_data_q;
  assign err           = err_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wen   = req_wen_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wstrb = req_wstrb_q;

endmodule
